// File: rtl/cmp_sort4_ctrl.sv
// Sorts four 4-bit entries in place, ascending, by bubble sort.
// A single magnitude comparator is shared by every compare step.
module cmp_mag4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] gel
);
  assign gel = {a > b, a == b, a < b};
endmodule

module cmp_sort4_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [1:0]  addr,
  input  logic [3:0]  din,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] data_out,
  output logic [2:0]  swaps,
  output logic [2:0]  cmp_r
);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t          state;
  logic [3:0][3:0] e;
  logic [1:0]      i, pass;
  logic            swapped;
  logic [3:0]      left, right;
  logic [2:0]      gel;
  logic            last;

  always_comb begin
    left  = e[i];
    right = e[i + 2'd1];
  end

  cmp_mag4 u_cmp (.a(left), .b(right), .gel(gel));

  // The final compare index of a pass shrinks by one each pass.
  assign last     = (i == (2'd2 - pass));
  assign data_out = e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      e       <= '0;
      i       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      swaps   <= '0;
      cmp_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) e[addr] <= din;
          if (start) begin
            state   <= SORT;
            busy    <= 1'b1;
            swaps   <= '0;
            pass    <= '0;
            i       <= '0;
            swapped <= 1'b0;
          end
        end
        SORT: begin
          cmp_r <= gel;
          if (gel[2]) begin
            e[i]        <= right;
            e[i + 2'd1] <= left;
            swaps       <= swaps + 3'd1;
          end
          if (last) begin
            // A pass without any swap means the entries are already ordered.
            if (pass == 2'd2 || !(swapped || gel[2])) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              pass    <= pass + 2'd1;
              i       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            i       <= i + 2'd1;
            swapped <= swapped | gel[2];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// Scoreboard bench for cmp_sort4_ctrl: expectations are queued at stimulus
// time and popped when the sort reports done.
module tb_cmp_sort4_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, load, start;
  logic [1:0]  addr;
  logic [3:0]  din;
  logic        busy, done;
  logic [15:0] data_out;
  logic [2:0]  swaps, cmp_r;

  always #5 clk = ~clk;

  cmp_sort4_ctrl dut (
    .clk(clk), .rst_n(rst_n), .load(load), .addr(addr), .din(din),
    .start(start), .busy(busy), .done(done), .data_out(data_out),
    .swaps(swaps), .cmp_r(cmp_r)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  swaps;
    logic [2:0]  cmp;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int          o_busy;
  bit          o_done;
  logic [15:0] o_data;
  logic [2:0]  o_sw, o_cmp;

  // Reference bubble sort with early exit when a pass makes no swap.
  function automatic exp_t model(input logic [3:0][3:0] v);
    exp_t r;
    logic [3:0] t;
    bit sw;
    r.swaps = 0; r.cmp = 0; r.cyc = 0;
    for (int p = 0; p < 3; p++) begin
      sw = 0;
      for (int j = 0; j < 3 - p; j++) begin
        r.cyc++;
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
          r.swaps++; sw = 1; r.cmp = 3'b100;
        end else if (v[j] == v[j+1]) r.cmp = 3'b010;
        else r.cmp = 3'b001;
      end
      if (!sw) break;
    end
    r.data = v;
    return r;
  endfunction

  // Loads (last load shares its cycle with start) or just starts, then
  // counts busy cycles until done, optionally poking load/start meanwhile.
  task automatic run(input logic [3:0][3:0] v, input bit do_load, input bit disturb);
    if (do_load) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); load = 1; addr = 2'(k); din = v[k]; start = (k == 3);
      end
    end else begin
      @(negedge clk); start = 1;
    end
    @(negedge clk); load = 0; start = 0;
    o_busy = 0; o_done = 0;
    for (int t = 0; t < 20 && !o_done; t++) begin
      if (done) begin
        o_done = 1; o_data = data_out; o_sw = swaps; o_cmp = cmp_r;
        load = 0; start = 0;
      end else begin
        if (busy) o_busy++;
        if (disturb && busy) begin load = 1; addr = 0; din = 0; start = 1; end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; load = 1; start = 1; addr = 0; din = 4'hF;
    repeat (3) @(negedge clk);
    total++; if (data_out !== 16'h0000) begin bad++; $display("FAIL reset data: got %h want 0000", data_out); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset busy/done: got %b want 00", {busy, done}); end
    total++; if ({swaps, cmp_r} !== 6'd0) begin bad++; $display("FAIL reset swaps/cmp: got %b want 000000", {swaps, cmp_r}); end
    rst_n = 1; load = 1; start = 0; addr = 0; din = 4'h5;
    @(negedge clk);
    load = 0;
    total++; if (data_out !== 16'h0005) begin bad++; $display("FAIL load after reset: got %h want 0005", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_sort_table;
    logic [3:0][3:0] vec [3];
    exp_t ex [3];
    exp_t e;
    vec[0] = 16'h1739; ex[0] = '{16'h9731, 3'd5, 3'b100, 6};
    vec[1] = 16'h4321; ex[1] = '{16'h4321, 3'd0, 3'b001, 3};
    vec[2] = 16'h5555; ex[2] = '{16'h5555, 3'd0, 3'b010, 3};
    for (int n = 0; n < 3; n++) begin
      q.push_back(ex[n]);
      run(vec[n], 1, 0);
      e = q.pop_front();
      total++; if (!o_done) begin bad++; $display("FAIL sort%0d timeout: no done", n); end
      total++; if (o_busy !== e.cyc) begin bad++; $display("FAIL sort%0d busy cycles: got %0d want %0d", n, o_busy, e.cyc); end
      total++; if (o_data !== e.data) begin bad++; $display("FAIL sort%0d data: got %h want %h", n, o_data, e.data); end
      total++; if (o_sw !== e.swaps) begin bad++; $display("FAIL sort%0d swaps: got %0d want %0d", n, o_sw, e.swaps); end
      total++; if (o_cmp !== e.cmp) begin bad++; $display("FAIL sort%0d cmp_r: got %b want %b", n, o_cmp, e.cmp); end
    end
  endtask

  task automatic test_ignore_in_sort;
    exp_t e;
    q.push_back('{16'hFEDC, 3'd6, 3'b100, 6});
    run(16'hCDEF, 1, 1);
    e = q.pop_front();
    total++; if (o_busy !== e.cyc) begin bad++; $display("FAIL ignore busy cycles: got %0d want %0d", o_busy, e.cyc); end
    total++; if (o_data !== e.data) begin bad++; $display("FAIL ignore data: got %h want %h", o_data, e.data); end
    total++; if (o_sw !== e.swaps) begin bad++; $display("FAIL ignore swaps: got %0d want %0d", o_sw, e.swaps); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL post-done flags: got %b want 00", {done, busy}); end
    total++; if (swaps !== 3'd6 || data_out !== 16'hFEDC) begin bad++; $display("FAIL idle hold: got %0d/%h want 6/fedc", swaps, data_out); end
  endtask

  task automatic test_back_to_back;
    logic [3:0][3:0] v;
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      v = 16'($urandom);
      q.push_back(model(v));
      run(v, 1, 0);
      e = q.pop_front();
      total++; if (!o_done || o_busy !== e.cyc) begin bad++; $display("FAIL rand%0d cycles: got %0d/%0b want %0d", n, o_busy, o_done, e.cyc); end
      total++; if (o_data !== e.data || o_sw !== e.swaps || o_cmp !== e.cmp) begin
        bad++; $display("FAIL rand%0d result: got %h/%0d/%b want %h/%0d/%b", n, o_data, o_sw, o_cmp, e.data, e.swaps, e.cmp);
      end
      // Restart straight away on the already sorted entries.
      q.push_back(model(e.data));
      run(e.data, 0, 0);
      e = q.pop_front();
      total++; if (!o_done || o_busy !== e.cyc || o_data !== e.data || o_sw !== 3'd0) begin
        bad++; $display("FAIL rerun%0d: got %0d/%h/%0d want %0d/%h/0", n, o_busy, o_data, o_sw, e.cyc, e.data);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0][3:0] v;
    int nb;
    v = 16'h1739;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); load = 1; addr = 2'(k); din = v[k]; start = (k == 3);
    end
    @(negedge clk); load = 0; start = 0;
    nb = 0;
    for (int t = 0; t < 10 && nb < 3; t++) begin
      if (busy) nb++;
      if (nb < 3) @(negedge clk);
    end
    total++; if (nb !== 3) begin bad++; $display("FAIL midreset reach: got %0d busy want 3", nb); end
    rst_n = 0;
    @(negedge clk);
    total++; if (data_out !== 16'h0000 || {busy, done} !== 2'b00) begin bad++; $display("FAIL midreset out: got %h/%b want 0000/00", data_out, {busy, done}); end
    total++; if ({swaps, cmp_r} !== 6'd0) begin bad++; $display("FAIL midreset regs: got %b want 000000", {swaps, cmp_r}); end
    rst_n = 1;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset after: got %b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset;
    test_sort_table;
    test_ignore_in_sort;
    test_back_to_back;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
